// File: rtl/inst_fetcher.sv
// Sequential fetch front-end: one outstanding i-cache request, in-order instruction queue
// toward the issuer, and flush/redirect handling that discards stale in-flight responses.
module inst_fetcher #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        reset_from_rob_bus,
  input  logic [31:0] pc_from_rob_bus,
  output logic        req_valid_to_icache,
  output logic [31:0] req_addr_to_icache,
  input  logic        req_ready_from_icache,
  input  logic        resp_valid_from_icache,
  input  logic [31:0] resp_inst_from_icache,
  output logic        valid_to_issuer,
  output logic [31:0] inst_to_issuer,
  output logic [31:0] pc_to_issuer,
  input  logic        ready_from_issuer
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [QUEUE_DEPTH];
  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic          flush, push, pop;

  assign flush = rdy_in && reset_from_rob_bus;

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // next-state logic; a flush turns an in-flight request into one whose answer is dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_to_icache && req_ready_from_icache) state_d = WAIT;
      WAIT: begin
        if (resp_valid_from_icache) state_d = IDLE;
        else if (flush)             state_d = DROP;
      end
      DROP: if (resp_valid_from_icache) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    req_valid_to_icache = rdy_in && (state_q == IDLE) && (count_q != DEPTH_C) && !flush;
    valid_to_issuer     = rdy_in && (count_q != '0) && !flush;
    push                = rdy_in && (state_q == WAIT) && resp_valid_from_icache && !flush;
    pop                 = valid_to_issuer && ready_from_issuer;
  end

  assign req_addr_to_icache = fetch_pc_q;
  assign inst_to_issuer     = inst_mem_q[head_q];
  assign pc_to_issuer       = pc_mem_q[head_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = pc_from_rob_bus;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tail_d     = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        inst_mem_q[tail_q] <= resp_inst_from_icache;
        pc_mem_q[tail_q]   <= fetch_pc_q;
      end
    end
  end

  // requests are only issued with room left, so a push can never land on a full queue
  assert property (@(posedge clk_in) disable iff (rst_in) push |-> (count_q != DEPTH_C));

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: an i-cache responder and a transaction-level queue
// model predict every request, redirect and word delivered to the issuer.
module tb_inst_fetcher;
  localparam int D = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, reset_from_rob_bus;
  logic [31:0] pc_from_rob_bus;
  logic        req_valid_to_icache, req_ready_from_icache;
  logic [31:0] req_addr_to_icache;
  logic        resp_valid_from_icache;
  logic [31:0] resp_inst_from_icache;
  logic        valid_to_issuer, ready_from_issuer;
  logic [31:0] inst_to_issuer, pc_to_issuer;

  always #5 clk_in = ~clk_in;

  inst_fetcher #(.QUEUE_DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .reset_from_rob_bus     (reset_from_rob_bus),
    .pc_from_rob_bus        (pc_from_rob_bus),
    .req_valid_to_icache    (req_valid_to_icache),
    .req_addr_to_icache     (req_addr_to_icache),
    .req_ready_from_icache  (req_ready_from_icache),
    .resp_valid_from_icache (resp_valid_from_icache),
    .resp_inst_from_icache  (resp_inst_from_icache),
    .valid_to_issuer        (valid_to_issuer),
    .inst_to_issuer         (inst_to_issuer),
    .pc_to_issuer           (pc_to_issuer),
    .ready_from_issuer      (ready_from_issuer)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: expected next fetch pc, the outstanding i-cache transaction and the word queue
  logic [31:0] exp_pc, out_addr, out_inst;
  bit          outst, stale;
  int          lat;
  logic [63:0] q[$];

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    rdy_in = 1'b0;
    reset_from_rob_bus = 1'b0;
    pc_from_rob_bus = 32'h0;
    req_ready_from_icache = 1'b0;
    resp_valid_from_icache = 1'b0;
    resp_inst_from_icache = 32'h0;
    ready_from_issuer = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, req_valid_to_icache}, 32'h0);
    chk("rst_req_addr", req_addr_to_icache, 32'h0);
    chk("rst_valid", {31'b0, valid_to_issuer}, 32'h0);
    chk("rst_inst", inst_to_issuer, 32'h0);
    chk("rst_pc", pc_to_issuer, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_pc = 32'h0; outst = 0; stale = 0; lat = 0;
    q.delete();
  endtask

  // one cycle: drive at negedge, check combinational outputs, then advance the model to the next posedge
  task automatic step(input int p_rdy, input int p_rq, input int p_fl, input int p_iss,
                      input int max_lat);
    bit fl, rsp, ev, erv;
    logic [31:0] fpc;
    @(negedge clk_in);
    rdy_in = ($urandom_range(99) < p_rdy);
    fl  = ($urandom_range(99) < p_fl);
    fpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    reset_from_rob_bus = fl;
    pc_from_rob_bus = fl ? fpc : $urandom;
    req_ready_from_icache = ($urandom_range(99) < p_rq);
    rsp = rdy_in && outst && (lat == 0);
    resp_valid_from_icache = rsp;
    resp_inst_from_icache = rsp ? out_inst : $urandom;
    ready_from_issuer = ($urandom_range(99) < p_iss);
    #1;
    ev  = rdy_in && (q.size() != 0) && !fl;
    erv = rdy_in && !outst && (q.size() < D) && !fl;
    chk("req_valid", {31'b0, req_valid_to_icache}, {31'b0, erv});
    chk("req_addr", req_addr_to_icache, exp_pc);
    chk("valid_to_issuer", {31'b0, valid_to_issuer}, {31'b0, ev});
    if (ev) begin
      chk("inst_to_issuer", inst_to_issuer, q[0][31:0]);
      chk("pc_to_issuer", pc_to_issuer, q[0][63:32]);
    end
    if (rdy_in) begin
      if (ev && ready_from_issuer) void'(q.pop_front());
      if (rsp) begin
        outst = 0;
        if (!stale && !fl) begin
          q.push_back({out_addr, out_inst});
          exp_pc = out_addr + 32'd4;
        end
      end
      if (fl) begin
        q.delete();
        exp_pc = fpc;
        stale = 1;
      end
      if (erv && req_ready_from_icache) begin
        outst = 1; stale = 0;
        out_addr = exp_pc;
        out_inst = $urandom;
        lat = $urandom_range(max_lat);
      end else if (outst && lat > 0) begin
        lat--;
      end
    end
  endtask

  initial begin
    do_reset();
    // zero-latency i-cache, stalled issuer: queue fills to depth, then drains
    repeat (40) step(100, 100, 0, 0, 0);
    repeat (30) step(100, 100, 0, 100, 0);
    // random traffic with flushes, stalls, variable latency and redirects near the pc wrap
    repeat (2000) step(85, 60, 6, 60, 3);
    do_reset();
    repeat (20) step(100, 100, 0, 100, 0);
    repeat (1500) step(80, 70, 10, 50, 2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
